// File: rtl/fml_vtx_txn_capture.sv
// fml_vtx_txn_capture
// Snoops a single-outstanding request/response data-memory interface and
// records up to NTXN completed transactions per retiring instruction. On
// instr_retire the collected slots are published one cycle later as a
// registered snapshot with vtx_valid, together with the fill count, an
// overflow flag and a sticky protocol-error flag.
module fml_vtx_txn_capture #(
    parameter int NTXN = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                       vtx_clk,
    input  logic                       vtx_reset,
    input  logic                       mem_req,
    input  logic                       mem_gnt,
    input  logic                       mem_wen,
    input  logic [AW-1:0]              mem_addr,
    input  logic [DW-1:0]              mem_wdata,
    input  logic [DW/8-1:0]            mem_ben,
    input  logic                       mem_recv,
    input  logic                       mem_ack,
    input  logic [DW-1:0]              mem_rdata,
    input  logic                       mem_error,
    input  logic                       instr_retire,
    output logic                       vtx_valid,
    output logic [NTXN-1:0]            vtx_mem_cen,
    output logic [NTXN-1:0]            vtx_mem_wen,
    output logic [NTXN-1:0]            vtx_mem_error,
    output logic [NTXN*AW-1:0]         vtx_mem_addr,
    output logic [NTXN*DW-1:0]         vtx_mem_wdata,
    output logic [NTXN*DW-1:0]         vtx_mem_rdata,
    output logic [NTXN*DW/8-1:0]       vtx_mem_ben,
    output logic [$clog2(NTXN+1)-1:0]  vtx_txn_count,
    output logic                       vtx_overflow,
    output logic                       vtx_proto_err
);

    localparam int BW = DW / 8;
    localparam int CW = $clog2(NTXN + 1);

    typedef enum logic {
        IDLE = 1'b0,  // no request outstanding
        PEND = 1'b1   // one request accepted, awaiting its response
    } state_t;

    state_t state, state_nxt;

    logic accept, complete;
    logic take_req;     // latch request payload into staging this edge
    logic fill;         // outstanding request completes this edge
    logic fill_keep;    // completion lands in a free slot
    logic fill_drop;    // completion arrives with all slots already used
    logic proto_hit;    // handshake seen that the protocol forbids

    // Staging for the single outstanding request
    logic          stg_wen;
    logic [AW-1:0] stg_addr;
    logic [DW-1:0] stg_wdata;
    logic [BW-1:0] stg_ben;

    // Per-slot storage for the current instruction, same layout as the outputs
    logic [NTXN-1:0]    slot_cen, slot_wen, slot_err;
    logic [NTXN*AW-1:0] slot_addr;
    logic [NTXN*DW-1:0] slot_wdata, slot_rdata;
    logic [NTXN*BW-1:0] slot_ben;
    logic [CW-1:0]      wr_ptr;
    logic               ovf;

    assign accept   = mem_req & mem_gnt;
    assign complete = mem_recv & mem_ack;

    // Handshake state register
    always_ff @(posedge vtx_clk or posedge vtx_reset) begin
        if (vtx_reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; an accept while PEND without a
    // completion is flagged and ignored, so the first request is kept
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case leaves a value unassigned (no latches).
        state_nxt = state;
        take_req  = 1'b0;
        fill      = 1'b0;
        proto_hit = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    take_req  = 1'b1;
                    state_nxt = PEND;
                end
                if (complete) proto_hit = 1'b1;
            end
            PEND: begin
                if (complete) begin
                    fill = 1'b1;
                    if (accept) take_req  = 1'b1;
                    else        state_nxt = IDLE;
                end else if (accept) begin
                    proto_hit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fill_keep = fill && (wr_ptr < CW'(NTXN));
    assign fill_drop = fill && !fill_keep;

    // Request staging; survives a retire so it completes into the next instruction
    always_ff @(posedge vtx_clk or posedge vtx_reset) begin
        if (vtx_reset) begin
            stg_wen   <= 1'b0;
            stg_addr  <= '0;
            stg_wdata <= '0;
            stg_ben   <= '0;
        end else if (take_req) begin
            stg_wen   <= mem_wen;
            stg_addr  <= mem_addr;
            stg_wdata <= mem_wdata;
            stg_ben   <= mem_ben;
        end
    end

    // Slot fill on completion; a retire empties every slot (its own
    // completion is bypassed straight into the snapshot below)
    always_ff @(posedge vtx_clk or posedge vtx_reset) begin
        if (vtx_reset) begin
            // NOTE: slot storage is reset, not left undefined, because
            // unfilled slots must present zero data in the snapshot.
            slot_cen   <= '0;
            slot_wen   <= '0;
            slot_err   <= '0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            slot_rdata <= '0;
            slot_ben   <= '0;
        end else if (instr_retire) begin
            slot_cen   <= '0;
            slot_wen   <= '0;
            slot_err   <= '0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            slot_rdata <= '0;
            slot_ben   <= '0;
        end else if (fill_keep) begin
            for (int i = 0; i < NTXN; i++) begin
                if (wr_ptr == CW'(i)) begin
                    slot_cen[i]              <= 1'b1;
                    slot_wen[i]              <= stg_wen;
                    slot_err[i]              <= mem_error;
                    slot_addr[i*AW +: AW]    <= stg_addr;
                    slot_wdata[i*DW +: DW]   <= stg_wdata;
                    slot_rdata[i*DW +: DW]   <= mem_rdata;
                    slot_ben[i*BW +: BW]     <= stg_ben;
                end
            end
        end
    end

    // Fill pointer (saturates at NTXN) and per-instruction overflow bit
    always_ff @(posedge vtx_clk or posedge vtx_reset) begin
        if (vtx_reset) begin
            wr_ptr <= '0;
            ovf    <= 1'b0;
        end else if (instr_retire) begin
            wr_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (fill_keep) wr_ptr <= wr_ptr + 1'b1;
            if (fill_drop) ovf    <= 1'b1;
        end
    end

    // Snapshot register: loaded on retire including a same-edge completion,
    // held until the next retire; vtx_valid pulses for one cycle
    always_ff @(posedge vtx_clk or posedge vtx_reset) begin
        if (vtx_reset) begin
            vtx_valid     <= 1'b0;
            vtx_mem_cen   <= '0;
            vtx_mem_wen   <= '0;
            vtx_mem_error <= '0;
            vtx_mem_addr  <= '0;
            vtx_mem_wdata <= '0;
            vtx_mem_rdata <= '0;
            vtx_mem_ben   <= '0;
            vtx_txn_count <= '0;
            vtx_overflow  <= 1'b0;
        end else begin
            vtx_valid <= instr_retire;
            if (instr_retire) begin
                vtx_mem_cen   <= slot_cen;
                vtx_mem_wen   <= slot_wen;
                vtx_mem_error <= slot_err;
                vtx_mem_addr  <= slot_addr;
                vtx_mem_wdata <= slot_wdata;
                vtx_mem_rdata <= slot_rdata;
                vtx_mem_ben   <= slot_ben;
                vtx_txn_count <= fill_keep ? wr_ptr + 1'b1 : wr_ptr;
                vtx_overflow  <= ovf | fill_drop;
                for (int i = 0; i < NTXN; i++) begin
                    if (fill_keep && (wr_ptr == CW'(i))) begin
                        vtx_mem_cen[i]              <= 1'b1;
                        vtx_mem_wen[i]              <= stg_wen;
                        vtx_mem_error[i]            <= mem_error;
                        vtx_mem_addr[i*AW +: AW]    <= stg_addr;
                        vtx_mem_wdata[i*DW +: DW]   <= stg_wdata;
                        vtx_mem_rdata[i*DW +: DW]   <= mem_rdata;
                        vtx_mem_ben[i*BW +: BW]     <= stg_ben;
                    end
                end
            end
        end
    end

    // Sticky protocol-error flag, cleared only by reset
    always_ff @(posedge vtx_clk or posedge vtx_reset) begin
        if (vtx_reset)      vtx_proto_err <= 1'b0;
        else if (proto_hit) vtx_proto_err <= 1'b1;
    end

endmodule
